// File: rtl/if_id_pipe_reg.sv
// IF/ID pipeline register: holds the fetched instruction word and exposes its
// raw RV32I fields (unextended immediates) to the decode stage.
module if_id_pipe_reg #(
  parameter logic [31:0] RST_INSTR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [31:0] instruction,
  output logic [6:0]  opcode,
  output logic [4:0]  rd,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [2:0]  funct3,
  output logic [6:0]  funct7,
  output logic [11:0] imm_I,
  output logic [11:0] imm_S,
  output logic [11:0] imm_B,
  output logic [19:0] imm_U,
  output logic [19:0] imm_J
);

  logic [31:0] instr_q;

  // IF -> ID boundary: reset wins over enable; enable low stalls the stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= RST_INSTR;
    end else if (enable) begin
      instr_q <= instruction;
    end
  end

  always_comb begin
    opcode = instr_q[6:0];
    rd     = instr_q[11:7];
    rs1    = instr_q[19:15];
    rs2    = instr_q[24:20];
    funct3 = instr_q[14:12];
    funct7 = instr_q[31:25];
    imm_I  = instr_q[31:20];
    imm_S  = {instr_q[31:25], instr_q[11:7]};
    imm_B  = {instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8]};
    imm_U  = instr_q[31:12];
    imm_J  = {instr_q[31], instr_q[19:12], instr_q[20], instr_q[30:21]};
  end

endmodule

// File: tb/tb_if_id_pipe_reg.sv
// Bench for the IF/ID pipeline register: directed decode cases, stall/reset
// behaviour, then randomized traffic against a word-level reference model.
module tb_if_id_pipe_reg;

  logic        clk;
  logic        rst;
  logic        enable;
  logic [31:0] instruction;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [11:0] imm_I;
  logic [11:0] imm_S;
  logic [11:0] imm_B;
  logic [19:0] imm_U;
  logic [19:0] imm_J;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] ref_word;

  if_id_pipe_reg #(.RST_INSTR(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .enable(enable), .instruction(instruction),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2), .funct3(funct3),
    .funct7(funct7), .imm_I(imm_I), .imm_S(imm_S), .imm_B(imm_B),
    .imm_U(imm_U), .imm_J(imm_J)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bits(input logic [31:0] w, input int lo, input int n);
    return (w >> lo) & ((32'd1 << n) - 32'd1);
  endfunction

  // Field model written straight from the RV32I field layout, one field at a time.
  task automatic check_word(input string tag, input logic [31:0] w);
    check({tag, ".opcode"}, {25'd0, opcode}, bits(w, 0, 7));
    check({tag, ".rd"},     {27'd0, rd},     bits(w, 7, 5));
    check({tag, ".rs1"},    {27'd0, rs1},    bits(w, 15, 5));
    check({tag, ".rs2"},    {27'd0, rs2},    bits(w, 20, 5));
    check({tag, ".funct3"}, {29'd0, funct3}, bits(w, 12, 3));
    check({tag, ".funct7"}, {25'd0, funct7}, bits(w, 25, 7));
    check({tag, ".imm_I"},  {20'd0, imm_I},  bits(w, 20, 12));
    check({tag, ".imm_S"},  {20'd0, imm_S},  bits(w, 25, 7) * 32 + bits(w, 7, 5));
    check({tag, ".imm_B"},  {20'd0, imm_B},
          bits(w, 31, 1) * 2048 + bits(w, 7, 1) * 1024 + bits(w, 25, 6) * 16 + bits(w, 8, 4));
    check({tag, ".imm_U"},  {12'd0, imm_U},  bits(w, 12, 20));
    check({tag, ".imm_J"},  {12'd0, imm_J},
          bits(w, 31, 1) * 524288 + bits(w, 12, 8) * 2048 + bits(w, 20, 1) * 1024 + bits(w, 21, 10));
  endtask

  // Apply inputs, take one edge, advance the reference word by the load rules.
  task automatic step(input logic r, input logic e, input logic [31:0] w);
    rst = r;
    enable = e;
    instruction = w;
    @(posedge clk);
    #1;
    if (r)      ref_word = 32'h0;
    else if (e) ref_word = w;
  endtask

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    instruction = 32'h0;
    ref_word = 32'h0;
    #2;

    step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b0, 32'h0);
    check_word("reset", 32'h0);
    check("reset.imm_J_const", {12'd0, imm_J}, 32'h0);

    step(1'b0, 1'b1, 32'h007302B3);
    check("add.opcode", {25'd0, opcode}, 32'h33);
    check("add.rd",     {27'd0, rd},     32'd5);
    check("add.rs1",    {27'd0, rs1},    32'd6);
    check("add.rs2",    {27'd0, rs2},    32'd7);
    check("add.funct3", {29'd0, funct3}, 32'd0);
    check("add.funct7", {25'd0, funct7}, 32'd0);
    check("add.imm_I",  {20'd0, imm_I},  32'h007);
    check("add.imm_S",  {20'd0, imm_S},  32'h005);
    check("add.imm_B",  {20'd0, imm_B},  32'h402);
    check("add.imm_U",  {12'd0, imm_U},  32'h00730);
    check("add.imm_J",  {12'd0, imm_J},  32'h18403);

    step(1'b0, 1'b1, 32'h00F58513);
    check("addi.opcode", {25'd0, opcode}, 32'h13);
    check("addi.rd",     {27'd0, rd},     32'd10);
    check("addi.rs1",    {27'd0, rs1},    32'd11);
    check("addi.imm_I",  {20'd0, imm_I},  32'h00F);
    check_word("addi", 32'h00F58513);

    step(1'b0, 1'b1, 32'h00208063);
    check("beq.opcode", {25'd0, opcode}, 32'h63);
    check("beq.rs1",    {27'd0, rs1},    32'd1);
    check("beq.rs2",    {27'd0, rs2},    32'd2);
    check("beq.imm_B",  {20'd0, imm_B},  32'h0);
    step(1'b0, 1'b0, 32'hFFFFFFFF);
    step(1'b0, 1'b0, 32'hFFFFFFFF);
    check_word("stall", 32'h00208063);

    instruction = 32'h12345678;
    #3;
    check_word("nocomb", 32'h00208063);

    step(1'b0, 1'b1, 32'hFFFFFFFF);
    check_word("ones", 32'hFFFFFFFF);
    check("ones.imm_J_const", {12'd0, imm_J}, 32'hFFFFF);
    step(1'b1, 1'b1, 32'hFFFFFFFF);
    check_word("rst_over_en", 32'h0);
    step(1'b0, 1'b0, 32'hFFFFFFFF);
    check_word("post_rst_hold", 32'h0);

    for (int i = 0; i < 300; i++) begin
      logic r, e;
      logic [31:0] w;
      r = ($urandom_range(0, 15) == 0);
      e = $urandom_range(0, 1) == 1;
      w = $urandom;
      step(r, e, w);
      check_word("rand", ref_word);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
